// File: rtl/ddr_prbs_chk.sv
// ddr_prbs_chk: receive-side PRBS31 checker for DDR read-back data, one checker per 32-bit lane.
// Each lane self-seeds from the data, locks, then feeds saturating word/bit error counters.
module ddr_prbs_chk #(
  parameter int AXI_DATA_WIDTH = 512,
  parameter int LOCK_CNT       = 4,
  parameter int LOSS_CNT       = 8,
  parameter int CNT_W          = 32,
  localparam int CH_NUM        = AXI_DATA_WIDTH / 32
) (
  input  logic                      clk_sys,
  input  logic                      reset,
  input  logic [CH_NUM-1:0]         chk_en,
  input  logic                      din_vld,
  input  logic [AXI_DATA_WIDTH-1:0] din,
  input  logic                      clr,
  output logic [CH_NUM-1:0]         lock,
  output logic                      all_lock,
  output logic [CH_NUM-1:0]         err_flag,
  output logic [CNT_W-1:0]          err_word_cnt,
  output logic [CNT_W-1:0]          bit_err_cnt
);

  localparam int MATCH_W = $clog2(LOCK_CNT + 1);
  localparam int MISS_W  = $clog2(LOSS_CNT + 1);
  localparam int LANE_W  = $clog2(CH_NUM + 1);
  localparam int BITS_W  = $clog2(AXI_DATA_WIDTH + 1);
  localparam int ACC_W   = ((CNT_W > BITS_W) ? CNT_W : BITS_W) + 1;

  typedef enum logic [1:0] {
    ST_UNLOCK,
    ST_SEED,
    ST_VERIFY,
    ST_LOCKED
  } lane_state_t;

  // Next 32-bit word from a 31-bit state; the first generated bit lands in bit 31.
  function automatic logic [31:0] prbs31_word(input logic [30:0] state);
    logic [30:0] s;
    logic        nb;
    logic [31:0] w;
    s = state;
    w = '0;
    for (int b = 31; b >= 0; b--) begin
      nb   = s[30] ^ s[27];
      w[b] = nb;
      s    = {s[29:0], nb};
    end
    return w;
  endfunction

  function automatic logic [5:0] popcount32(input logic [31:0] v);
    logic [5:0] c;
    c = '0;
    for (int b = 0; b < 32; b++) begin
      c = c + {5'd0, v[b]};
    end
    return c;
  endfunction

  logic [CH_NUM-1:0] lane_err;
  logic [5:0]        lane_pop [CH_NUM];

  genvar gi;
  generate
    for (gi = 0; gi < CH_NUM; gi++) begin : g_lane
      lane_state_t        state_reg;
      logic [30:0]        lfsr_reg;
      logic [MATCH_W-1:0] match_cnt_reg;
      logic [MISS_W-1:0]  miss_cnt_reg;
      logic               lock_reg;
      logic               err_reg;
      logic [31:0]        mask_reg;
      logic [31:0]        word;
      logic [31:0]        pred;
      logic               seed_ok;
      logic               hit;

      assign word    = din[32*gi +: 32];
      assign pred    = prbs31_word(lfsr_reg);
      assign seed_ok = (word[30:0] != 31'd0);
      assign hit     = (word == pred);

      always_ff @(posedge clk_sys or negedge reset) begin
        if (!reset) begin
          state_reg     <= ST_UNLOCK;
          lfsr_reg      <= '0;
          match_cnt_reg <= '0;
          miss_cnt_reg  <= '0;
          lock_reg      <= 1'b0;
          err_reg       <= 1'b0;
          mask_reg      <= '0;
        end else begin
          err_reg  <= 1'b0;
          mask_reg <= '0;
          if (!chk_en[gi]) begin
            state_reg <= ST_UNLOCK;
            lock_reg  <= 1'b0;
          end else if (din_vld) begin
            case (state_reg)
              ST_UNLOCK, ST_SEED: begin
                if (seed_ok) begin
                  lfsr_reg      <= word[30:0];
                  match_cnt_reg <= '0;
                  state_reg     <= ST_VERIFY;
                end else begin
                  state_reg <= ST_SEED;
                end
              end
              ST_VERIFY: begin
                if (hit) begin
                  lfsr_reg <= pred[30:0];
                  if (match_cnt_reg == MATCH_W'(LOCK_CNT - 1)) begin
                    state_reg    <= ST_LOCKED;
                    lock_reg     <= 1'b1;
                    miss_cnt_reg <= '0;
                  end else begin
                    match_cnt_reg <= match_cnt_reg + 1'b1;
                  end
                end else if (seed_ok) begin
                  lfsr_reg      <= word[30:0];
                  match_cnt_reg <= '0;
                end else begin
                  state_reg <= ST_SEED;
                end
              end
              ST_LOCKED: begin
                // Free-running once locked: a corrupted word never pollutes the prediction.
                lfsr_reg <= pred[30:0];
                if (!hit) begin
                  err_reg  <= 1'b1;
                  mask_reg <= word ^ pred;
                  if (miss_cnt_reg == MISS_W'(LOSS_CNT - 1)) begin
                    state_reg <= ST_SEED;
                    lock_reg  <= 1'b0;
                  end else begin
                    miss_cnt_reg <= miss_cnt_reg + 1'b1;
                  end
                end else begin
                  miss_cnt_reg <= '0;
                end
              end
              default: state_reg <= ST_UNLOCK;
            endcase
          end
        end
      end

      assign lock[gi]     = lock_reg;
      assign lane_err[gi] = err_reg;
      assign lane_pop[gi] = popcount32(mask_reg);
    end
  endgenerate

  logic [LANE_W-1:0] err_lanes;
  logic [BITS_W-1:0] err_bits;

  always_comb begin
    err_lanes = '0;
    err_bits  = '0;
    for (int i = 0; i < CH_NUM; i++) begin
      err_lanes = err_lanes + LANE_W'(lane_err[i]);
      err_bits  = err_bits + BITS_W'(lane_pop[i]);
    end
  end

  logic [CNT_W-1:0]  word_cnt_reg;
  logic [CNT_W-1:0]  bit_cnt_reg;
  logic [CH_NUM-1:0] err_flag_reg;
  logic [ACC_W-1:0]  word_sum;
  logic [ACC_W-1:0]  bit_sum;
  logic [CNT_W-1:0]  word_cnt_next;
  logic [CNT_W-1:0]  bit_cnt_next;

  // One spare MSB on the adders detects overflow so the counters pin at all-ones.
  assign word_sum      = ACC_W'(word_cnt_reg) + ACC_W'(err_lanes);
  assign bit_sum       = ACC_W'(bit_cnt_reg) + ACC_W'(err_bits);
  assign word_cnt_next = (word_sum[ACC_W-1:CNT_W] != '0) ? {CNT_W{1'b1}} : word_sum[CNT_W-1:0];
  assign bit_cnt_next  = (bit_sum[ACC_W-1:CNT_W] != '0) ? {CNT_W{1'b1}} : bit_sum[CNT_W-1:0];

  always_ff @(posedge clk_sys or negedge reset) begin
    if (!reset) begin
      word_cnt_reg <= '0;
      bit_cnt_reg  <= '0;
      err_flag_reg <= '0;
    end else if (clr) begin
      word_cnt_reg <= '0;
      bit_cnt_reg  <= '0;
      err_flag_reg <= '0;
    end else begin
      word_cnt_reg <= word_cnt_next;
      bit_cnt_reg  <= bit_cnt_next;
      err_flag_reg <= err_flag_reg | lane_err;
    end
  end

  assign err_word_cnt = word_cnt_reg;
  assign bit_err_cnt  = bit_cnt_reg;
  assign err_flag     = err_flag_reg;
  assign all_lock     = (chk_en != '0) && (&(lock | ~chk_en));

endmodule

// File: tb/tb_ddr_prbs_chk.sv
// tb_ddr_prbs_chk: drives a 16-lane checker and a 4-lane, 4-bit-counter checker from one stream
// and compares both against a bit-stream PRBS31 reference model.
module tb_ddr_prbs_chk;
  localparam int W      = 512;
  localparam int CH     = 16;
  localparam int SW     = 128;
  localparam int SCH    = 4;
  localparam int LOCK_N = 4;
  localparam int LOSS_N = 8;
  localparam longint MAIN_MAX  = 64'h0000_0000_FFFF_FFFF;
  localparam longint SMALL_MAX = 64'd15;
  localparam int M_UNLOCK = 0, M_SEED = 1, M_VERIFY = 2, M_LOCKED = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic [CH-1:0] chk_en;
  logic          din_vld;
  logic [W-1:0]  din;
  logic          clr;
  logic [CH-1:0] lock;
  logic          all_lock;
  logic [CH-1:0] err_flag;
  logic [31:0]   err_word_cnt;
  logic [31:0]   bit_err_cnt;
  logic [SCH-1:0] s_lock;
  logic           s_all_lock;
  logic [SCH-1:0] s_err_flag;
  logic [3:0]     s_word_cnt;
  logic [3:0]     s_bit_cnt;

  int n_pass = 0;
  int n_total = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  ddr_prbs_chk #(.AXI_DATA_WIDTH(W), .LOCK_CNT(LOCK_N), .LOSS_CNT(LOSS_N), .CNT_W(32)) u_dut (
    .clk_sys(clk), .reset(reset), .chk_en(chk_en), .din_vld(din_vld), .din(din), .clr(clr),
    .lock(lock), .all_lock(all_lock), .err_flag(err_flag),
    .err_word_cnt(err_word_cnt), .bit_err_cnt(bit_err_cnt)
  );

  ddr_prbs_chk #(.AXI_DATA_WIDTH(SW), .LOCK_CNT(LOCK_N), .LOSS_CNT(LOSS_N), .CNT_W(4)) u_small (
    .clk_sys(clk), .reset(reset), .chk_en(chk_en[SCH-1:0]), .din_vld(din_vld), .din(din[SW-1:0]),
    .clr(clr), .lock(s_lock), .all_lock(s_all_lock), .err_flag(s_err_flag),
    .err_word_cnt(s_word_cnt), .bit_err_cnt(s_bit_cnt)
  );

  // Reference model state
  int          m_st    [CH];
  logic [30:0] m_s     [CH];
  int          m_match [CH];
  int          m_miss  [CH];
  bit          pend_err  [CH];
  int          pend_bits [CH];
  longint      exp_word, exp_bit, exp_sword, exp_sbit;
  logic [CH-1:0]  exp_flag;
  logic [SCH-1:0] exp_sflag;

  // Stimulus generators, one PRBS31 stream per lane
  logic [30:0] gen_s [CH];
  logic [CH-1:0] en_cur;

  // Stream view: x[n] = x[n-31] ^ x[n-28]; x[0..30] is the state, oldest first.
  function automatic logic [31:0] prbs_next_word(input logic [30:0] s);
    bit x [63];
    logic [31:0] w;
    for (int k = 0; k < 31; k++) x[k] = s[30-k];
    for (int n = 31; n < 63; n++) x[n] = x[n-31] ^ x[n-28];
    for (int j = 0; j < 32; j++) w[31-j] = x[31+j];
    return w;
  endfunction

  function automatic longint sat(input longint v, input longint mx);
    return (v > mx) ? mx : v;
  endfunction

  function automatic logic [CH-1:0] exp_lock_vec();
    logic [CH-1:0] v;
    for (int l = 0; l < CH; l++) v[l] = (m_st[l] == M_LOCKED);
    return v;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int l = 0; l < CH; l++) begin
      m_st[l] = M_UNLOCK; m_s[l] = '0; m_match[l] = 0; m_miss[l] = 0;
      pend_err[l] = 0; pend_bits[l] = 0;
    end
    exp_word = 0; exp_bit = 0; exp_sword = 0; exp_sbit = 0;
    exp_flag = '0; exp_sflag = '0;
  endtask

  task automatic model_seed(input int l, input logic [31:0] w);
    if (w[30:0] == 31'd0) m_st[l] = M_SEED;
    else begin
      m_s[l] = w[30:0]; m_match[l] = 0; m_st[l] = M_VERIFY;
    end
  endtask

  task automatic model_edge(input logic v, input logic [W-1:0] d, input logic [CH-1:0] en, input logic c);
    longint nw, nb, snw, snb;
    logic [31:0] w, p;
    nw = 0; nb = 0; snw = 0; snb = 0;
    for (int l = 0; l < CH; l++) begin
      if (pend_err[l]) begin
        nw++; nb += pend_bits[l];
        if (l < SCH) begin snw++; snb += pend_bits[l]; end
      end
    end
    if (c) begin
      exp_word = 0; exp_bit = 0; exp_sword = 0; exp_sbit = 0; exp_flag = '0; exp_sflag = '0;
    end else begin
      exp_word  = sat(exp_word + nw, MAIN_MAX);
      exp_bit   = sat(exp_bit + nb, MAIN_MAX);
      exp_sword = sat(exp_sword + snw, SMALL_MAX);
      exp_sbit  = sat(exp_sbit + snb, SMALL_MAX);
      for (int l = 0; l < CH; l++) begin
        if (pend_err[l]) exp_flag[l] = 1'b1;
        if (pend_err[l] && l < SCH) exp_sflag[l] = 1'b1;
      end
    end
    for (int l = 0; l < CH; l++) begin
      pend_err[l] = 0; pend_bits[l] = 0;
      w = d[32*l +: 32];
      if (!en[l]) m_st[l] = M_UNLOCK;
      else if (v) begin
        p = prbs_next_word(m_s[l]);
        case (m_st[l])
          M_UNLOCK, M_SEED: model_seed(l, w);
          M_VERIFY: begin
            if (w == p) begin
              m_s[l] = w[30:0]; m_match[l]++;
              if (m_match[l] == LOCK_N) begin m_st[l] = M_LOCKED; m_miss[l] = 0; end
            end else model_seed(l, w);
          end
          default: begin
            m_s[l] = p[30:0];
            if (w != p) begin
              pend_err[l] = 1; pend_bits[l] = $countones(w ^ p); m_miss[l]++;
              if (m_miss[l] == LOSS_N) m_st[l] = M_SEED;
            end else m_miss[l] = 0;
          end
        endcase
      end
    end
  endtask

  task automatic check_all();
    logic [CH-1:0] el;
    logic ea, esa;
    el  = exp_lock_vec();
    ea  = (chk_en != '0) && (&(el | ~chk_en));
    esa = (chk_en[SCH-1:0] != '0) && (&(el[SCH-1:0] | ~chk_en[SCH-1:0]));
    chk("lock", 32'(lock), 32'(el));
    chk("all_lock", 32'(all_lock), 32'(ea));
    chk("err_flag", 32'(err_flag), 32'(exp_flag));
    chk("err_word_cnt", err_word_cnt, 32'(exp_word));
    chk("bit_err_cnt", bit_err_cnt, 32'(exp_bit));
    chk("s_lock", 32'(s_lock), 32'(el[SCH-1:0]));
    chk("s_all_lock", 32'(s_all_lock), 32'(esa));
    chk("s_err_flag", 32'(s_err_flag), 32'(exp_sflag));
    chk("s_word_cnt", 32'(s_word_cnt), 32'(exp_sword));
    chk("s_bit_cnt", 32'(s_bit_cnt), 32'(exp_sbit));
  endtask

  // Inputs change at the falling edge; outputs are checked at the next falling edge.
  task automatic step(input logic v, input logic [W-1:0] d, input logic [CH-1:0] en, input logic c);
    din_vld = v; din = d; chk_en = en; clr = c;
    @(posedge clk);
    model_edge(v, d, en, c);
    @(negedge clk);
    check_all();
  endtask

  task automatic next_clean(output logic [W-1:0] d);
    logic [31:0] w;
    for (int l = 0; l < CH; l++) begin
      w = prbs_next_word(gen_s[l]);
      gen_s[l] = w[30:0];
      d[32*l +: 32] = w;
    end
  endtask

  task automatic rand_beat(output logic [W-1:0] d);
    for (int l = 0; l < CH; l++) d[32*l +: 32] = $urandom;
  endtask

  task automatic beat_err(input logic [W-1:0] xm, input logic c);
    logic [W-1:0] d;
    next_clean(d);
    step(1'b1, d ^ xm, en_cur, c);
  endtask

  task automatic beat_clean();
    beat_err('0, 1'b0);
  endtask

  initial begin
    logic [W-1:0] d;
    logic [W-1:0] xm;
    logic [31:0] r;
    logic v, c;
    int l;

    reset = 1'b0; chk_en = '0; din_vld = 1'b0; din = '0; clr = 1'b0;
    en_cur = '1;
    model_reset();
    repeat (3) @(negedge clk);
    check_all();
    reset = 1'b1;

    // All-zero data never yields a legal seed
    for (int i = 0; i < 20; i++) step(1'b1, '0, en_cur, 1'b0);
    chk("zero_no_lock", 32'(lock), 32'd0);

    // Seed every lane with 32'hFFFF_FFFF then four matching words
    d = '1;
    for (int i = 0; i < CH; i++) gen_s[i] = 31'h7FFF_FFFF;
    step(1'b1, d, en_cur, 1'b0);
    for (int i = 0; i < LOCK_N; i++) beat_clean();
    chk("lock_after_word4", 32'(lock), 32'h0000_FFFF);
    chk("all_lock_after_word4", 32'(all_lock), 32'd1);

    for (int i = 0; i < 10000; i++) beat_clean();
    chk("clean_word_cnt", err_word_cnt, 32'd0);

    // Single bit error on lane 3 bit 5
    xm = '0; xm[3*32 + 5] = 1'b1;
    beat_err(xm, 1'b0);
    beat_clean();
    chk("single_flag", 32'(err_flag), 32'h0000_0008);
    chk("single_word", err_word_cnt, 32'd1);
    chk("single_bit", bit_err_cnt, 32'd1);
    for (int i = 0; i < 5; i++) beat_clean();

    // Whole-word inversion on lanes 0 and 15
    xm = '0; xm[31:0] = '1; xm[W-1 -: 32] = '1;
    beat_err(xm, 1'b0);
    beat_clean();
    chk("burst_word", err_word_cnt, 32'd3);
    chk("burst_bit", bit_err_cnt, 32'd65);

    // Loss of lock on lane 7, then re-lock from the clean stream
    for (int i = 0; i < LOSS_N; i++) begin
      xm = '0; r = $urandom; if (r == 0) r = 32'd1;
      xm[7*32 +: 32] = r;
      beat_err(xm, 1'b0);
    end
    chk("loss_lock", 32'(lock), 32'h0000_FF7F);
    for (int i = 0; i < LOCK_N + 1; i++) beat_clean();
    chk("relock_lane7", 32'(lock), 32'h0000_FFFF);
    chk("loss_word", err_word_cnt, 32'd11);

    // Idle cycles between beats
    for (int i = 0; i < 50; i++) begin
      beat_clean();
      rand_beat(d);
      step(1'b0, d, en_cur, 1'b0);
    end

    // clr wins over the increment due on the same edge
    xm = '0; xm[3*32 + 5] = 1'b1;
    beat_err(xm, 1'b0);
    beat_err('0, 1'b1);
    chk("clr_word", err_word_cnt, 32'd0);
    chk("clr_flag", 32'(err_flag), 32'd0);
    chk("clr_keeps_lock", 32'(lock), 32'h0000_FFFF);
    beat_clean();
    chk("clr_discard", bit_err_cnt, 32'd0);

    // Drive the 4-bit counters of the small instance into saturation
    xm = '0; xm[5] = 1'b1; xm[32 + 5] = 1'b1; xm[64 + 5] = 1'b1;
    for (int i = 0; i < 4; i++) beat_err(xm, 1'b0);
    xm[64 + 5] = 1'b0;
    beat_err(xm, 1'b0);
    beat_clean();
    chk("s_word_14", 32'(s_word_cnt), 32'd14);
    xm[64 + 5] = 1'b1;
    beat_err(xm, 1'b0);
    beat_clean();
    chk("s_word_sat", 32'(s_word_cnt), 32'd15);
    chk("main_word_17", err_word_cnt, 32'd17);
    for (int i = 0; i < 3; i++) beat_clean();

    // Lane enables: drop lane 9, then everything
    en_cur = 16'hFDFF;
    for (int i = 0; i < 3; i++) beat_clean();
    en_cur = '1;
    for (int i = 0; i < LOCK_N + 1; i++) beat_clean();
    en_cur = '0;
    beat_clean();
    chk("all_lock_none_enabled", 32'(all_lock), 32'd0);
    en_cur = '1;
    for (int i = 0; i < LOCK_N + 2; i++) beat_clean();

    // Randomized traffic: gaps, corrupted lanes, enables and occasional clr
    for (int i = 0; i < 600; i++) begin
      v = ($urandom_range(3) != 0);
      c = ($urandom_range(40) == 0);
      if ($urandom_range(60) == 0) en_cur = 16'($urandom);
      else if ($urandom_range(15) == 0) en_cur = '1;
      if (v) begin
        next_clean(d);
        if ($urandom_range(3) == 0) begin
          l = $urandom_range(CH - 1);
          r = $urandom; if (r == 0) r = 32'd1;
          d[32*l +: 32] = d[32*l +: 32] ^ r;
        end
      end else rand_beat(d);
      step(v, d, en_cur, c);
    end
    en_cur = '1;
    for (int i = 0; i < 10; i++) beat_clean();

    // Asynchronous reset in the middle of the stream
    reset = 1'b0;
    #1;
    model_reset();
    chk("rst_lock", 32'(lock), 32'd0);
    chk("rst_word", err_word_cnt, 32'd0);
    check_all();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < LOCK_N; i++) beat_clean();
    chk("rst_no_early_lock", 32'(lock), 32'd0);
    beat_clean();
    chk("rst_relock", 32'(lock), 32'h0000_FFFF);
    for (int i = 0; i < 5; i++) beat_clean();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/ddr_prbs_chk.md
Name: ddr_prbs_chk

Overview:
- Receive-side checker for DDR read-back data written by the team's per-lane PRBS31 generator.
- Splits each AXI read beat into AXI_DATA_WIDTH/32 independent 32-bit lanes.
- Each lane self-seeds from the incoming data, locks onto the PRBS31 sequence, then compares every later word against a locally advanced LFSR.
- Sits between the AXI read-data path and the test status/CSR block; reports lock, sticky error flags and saturating error counters.

Parameters:
- AXI_DATA_WIDTH, 512, read data width; must be a multiple of 32. CH_NUM = AXI_DATA_WIDTH/32.
- LOCK_CNT, 4, consecutive matching words required after seeding before a lane declares lock.
- LOSS_CNT, 8, consecutive mismatching words while locked that force a lane to re-seed.
- CNT_W, 32, width of the error counters.

Ports:
- clk_sys  in  1  system clock.
- reset  in  1  asynchronous reset, active low.
- chk_en  in  CH_NUM  per-lane enable. Low holds the lane in UNLOCK.
- din_vld  in  1  read beat valid.
- din  in  AXI_DATA_WIDTH  read data; lane i = din[32*i+:32].
- clr  in  1  synchronous clear of counters and sticky flags.
- lock  out  CH_NUM  per-lane locked.
- all_lock  out  1  AND of lock over enabled lanes; 0 if chk_en == 0.
- err_flag  out  CH_NUM  sticky: lane saw at least one mismatching word while locked.
- err_word_cnt  out  CNT_W  total mismatching lane-words while locked, saturating.
- bit_err_cnt  out  CNT_W  total mismatching bits while locked, saturating.

Behaviour:
- PRBS31 convention (matches the generator):
  - Polynomial x^31+x^28+1; state s[30:0].
  - Each step: new bit = s[30]^s[27]; s = {s[29:0], new bit}.
  - One word = 32 steps; word bit 31 is the first generated bit.
  - State after a word equals word[30:0], so one word fully determines the next.
- Per-lane FSM. On reset every lane is in UNLOCK and all outputs are 0.
  - UNLOCK: when chk_en[i] is 1 and din_vld is 1, go to SEED and treat that word as the seed (same handling as a SEED arrival).
  - SEED, valid word w arrives:
    - If w[30:0] == 0, reject it (all-zero state is illegal) and stay in SEED.
    - Otherwise load s = w[30:0], clear match_cnt, go to VERIFY.
  - VERIFY, valid word arrives: compare with prediction P(s).
    - Match: advance s and increment match_cnt. When match_cnt reaches LOCK_CNT, go to LOCKED.
    - Mismatch: re-seed from this word per the SEED rules, staying in VERIFY (or returning to SEED if its low 31 bits are zero).
  - LOCKED, valid word arrives: always advance s from local state, never reloaded from data, so one corrupted word gives exactly one error.
    - Mismatch: count errors, increment miss_cnt. When miss_cnt reaches LOSS_CNT, go to SEED.
    - Match: clear miss_cnt.
  - chk_en[i] low in any state: return to UNLOCK next cycle; counter contents are kept.
  - din_vld low: no state change.
- Pipeline and latency (word accepted at edge T):
  - Lane compare result, mismatch bit mask and FSM update are registered at T+1.
  - lock[i] rises at T+1 after the LOCK_CNT-th matching word.
  - Popcount and accumulation are registered, so err_flag, err_word_cnt and bit_err_cnt update at T+2.
  - Only words that arrive while a lane is already LOCKED contribute to errors.
- Arithmetic:
  - Per beat, err_word_cnt adds the count of erroring lanes (0..CH_NUM).
  - bit_err_cnt adds the popcount of the mismatch mask (0..AXI_DATA_WIDTH).
  - Both counters saturate at 2^CNT_W-1 and never wrap.
- clr:
  - Zeroes both counters and err_flag next cycle; has priority over any increment arriving in the same cycle, and that increment is discarded.
  - Does not affect lock or FSM state.
- Reset asserted mid-stream: all lanes go to UNLOCK and all outputs clear immediately (asynchronously). Re-lock requires a fresh seed word plus LOCK_CNT matching words.

Test Plan:
- Clean lock: CH_NUM=16, chk_en=16'hFFFF, every lane's generator seeded 32'hFFFF_FFFF, din_vld held high. Word0 seeds, words 1-4 match -> lock=16'hFFFF and all_lock=1 exactly one cycle after word 4; counters stay 0 over 10000 beats.
- Single-bit error: once locked, flip bit 5 of lane 3 in one beat -> err_flag=16'h0008, err_word_cnt=1 and bit_err_cnt=1 at T+2; lock stays asserted; no further errors on following beats.
- Multi-lane burst: in one beat, invert all 32 bits of lanes 0 and 15 -> err_word_cnt +=2, bit_err_cnt +=64.
- Loss of lock: corrupt lane 7 for 8 consecutive beats, then resume a clean stream -> lock[7] drops after the 8th bad word, other lanes stay locked; lane 7 re-locks after 1 seed word + 4 matching words; err_word_cnt[lane 7 contribution]=8.
- Zero and gap handling:
  - All-zero data -> lock stays 0 forever.
  - Clean stream with din_vld toggled 1-0-1 -> lock and counters unaffected by idle cycles.
- clr priority and reset: assert clr in the same cycle an error increment is due -> counters read 0 afterwards. Separately, preset counters to 2^32-2 and inject 3 lane errors -> err_word_cnt=32'hFFFF_FFFF. Pull reset low mid-stream -> lock=0 and all counters 0 immediately.
